// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: per-latch write enables and bubble flushes for F/D, D/X, X/M, M/W and PC.
// Latency: all outputs are combinational from state and inputs; only state and the mult/div counter are registered.
// Backpressure: a mult/div freezes PC/F/D/D/X and bubbles X/M; a load-use hazard freezes PC/F/D for one bubble. Optional macro PIPELINE_CTRL_PERF_EN adds stall/flush counters.
module pipeline_ctrl #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       dx_is_load,
    input  logic [4:0] dx_rd,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       branch_taken,
    output logic       pc_we,
    output logic       fd_we,
    output logic       dx_we,
    output logic       xm_we,
    output logic       mw_we,
    output logic       fd_flush,
    output logic       dx_flush,
    output logic       xm_flush,
    output logic       md_busy,
    output logic       md_done
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The start cycle and the DONE cycle are part of the occupancy, so BUSY lasts N-2 cycles.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] md_load;
    logic             load_use;

    assign md_load  = md_is_div ? DIV_LOAD : MULT_LOAD;
    assign load_use = dx_is_load && (dx_rd != 5'd0) && ((dx_rd == fd_rs) || (dx_rd == fd_rt));

    // Sequencer: load the occupancy count on start, count down in BUSY, one DONE cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        cnt <= md_load;
                        // A two-cycle op has no BUSY cycles at all.
                        state <= (md_load == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    // Leave on the edge where the count reaches zero.
                    if (cnt <= CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode: mult/div stall beats branch flush, which beats load-use stall.
    always_comb begin
        pc_we    = 1'b1;
        fd_we    = 1'b1;
        dx_we    = 1'b1;
        xm_we    = 1'b1;
        mw_we    = 1'b1;
        fd_flush = 1'b0;
        dx_flush = 1'b0;
        xm_flush = 1'b0;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        case (state)
            IDLE: begin
                if (md_start) begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_we    = 1'b0;
                    xm_flush = 1'b1;
                end else if (branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (load_use) begin
                    pc_we    = 1'b0;
                    fd_we    = 1'b0;
                    dx_flush = 1'b1;
                end
            end
            BUSY: begin
                pc_we    = 1'b0;
                fd_we    = 1'b0;
                dx_we    = 1'b0;
                xm_flush = 1'b1;
                md_busy  = 1'b1;
            end
            DONE: begin
                md_done = 1'b1;
            end
            default: begin
                md_done = 1'b0;
            end
        endcase
    end

`ifdef PIPELINE_CTRL_PERF_EN
    // Stall cycles: any cycle in which the PC is frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (!pc_we) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    // Flush cycles: any cycle in which F/D receives a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_count <= '0;
        end else if (fd_flush) begin
            flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, hand-written mult/div and reset sequences, randomized run vs. reference model.
module tb_pipeline_ctrl;

    localparam int MULT_N = 32;
    localparam int DIV_N  = 32;

    // Output vector order: {pc,fd,dx,xm,mw, fd_flush,dx_flush,xm_flush, busy,done}
    localparam logic [9:0] O_NORM = 10'b11111_000_00;
    localparam logic [9:0] O_LU   = 10'b00111_010_00;
    localparam logic [9:0] O_BR   = 10'b11111_110_00;
    localparam logic [9:0] O_DONE = 10'b11111_000_01;

    logic       clock;
    logic       reset;
    logic       md_start, md_is_div, dx_is_load, branch_taken;
    logic [4:0] dx_rd, fd_rs, fd_rt;
    logic       pc_we, fd_we, dx_we, xm_we, mw_we;
    logic       fd_flush, dx_flush, xm_flush, md_busy, md_done;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    pipeline_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .md_start(md_start), .md_is_div(md_is_div),
        .dx_is_load(dx_is_load), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .branch_taken(branch_taken),
        .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .xm_we(xm_we), .mw_we(mw_we),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
        .md_busy(md_busy), .md_done(md_done)
`ifdef PIPELINE_CTRL_PERF_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    logic [9:0] outs;
    assign outs = {pc_we, fd_we, dx_we, xm_we, mw_we, fd_flush, dx_flush, xm_flush, md_busy, md_done};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: how many cycles the current mult/div has already spent in X (0 = none).
    int occ   = 0;
    int n_cur = MULT_N;
    logic [9:0] last;

    typedef struct {
        string      name;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] model_step(input logic st, input logic dv, input logic ld,
                                              input logic [4:0] rd, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic br);
        int pos;
        logic [9:0] e;
        pos = 0;
        if (occ > 0) begin
            pos = occ + 1;
        end else if (st) begin
            pos   = 1;
            n_cur = dv ? DIV_N : MULT_N;
        end
        if (pos > 0) begin
            if (pos < n_cur) e = {5'b00011, 3'b001, (pos > 1), 1'b0};
            else             e = O_DONE;
            occ = (pos >= n_cur) ? 0 : pos;
        end else if (br) begin
            e = O_BR;
        end else if (ld && rd != 5'd0 && (rd == rs || rd == rt)) begin
            e = O_LU;
        end else begin
            e = O_NORM;
        end
        return e;
    endfunction

    // One clock cycle: drive, compare against the model mid-cycle, advance.
    task automatic cycle(input logic st, input logic dv, input logic ld, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic br);
        logic [9:0] e;
        md_start = st; md_is_div = dv; dx_is_load = ld;
        dx_rd = rd; fd_rs = rs; fd_rt = rt; branch_taken = br;
        @(negedge clock);
        e = model_step(st, dv, ld, rd, rs, rt, br);
        check("model", {22'd0, outs}, {22'd0, e});
        last = outs;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        md_start = 0; md_is_div = 0; dx_is_load = 0; dx_rd = 0; fd_rs = 0; fd_rt = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        occ = 0;
        #2;
        check("reset_outs", {22'd0, outs}, {22'd0, O_NORM});
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Issues one mult/div and checks stall length and the single done pulse.
    task automatic run_md(input string nm, input logic dv, input int n);
        int stalls;
        int done_at;
        int dones;
        stalls = 0; done_at = 0; dones = 0;
        cycle(1'b1, dv, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        if (!last[9]) stalls++;
        for (int i = 2; i <= n + 4; i++) begin
            // Branch and load-use hazards during BUSY must be ignored.
            if (i >= 10 && i <= 12) cycle(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
            else                    cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            if (!last[9]) stalls++;
            if (last[0]) begin
                dones++;
                if (done_at == 0) done_at = i;
            end
        end
        check({nm, "_stall_cycles"}, stalls, n - 1);
        check({nm, "_done_cycle"}, done_at, n);
        check({nm, "_done_pulses"}, dones, 1);
    endtask

    initial begin
        tbl[0] = '{"lu_none",        1'b0, 5'd0,  5'd0,  5'd0, 1'b0, O_NORM};
        tbl[1] = '{"lu_rt",          1'b1, 5'd5,  5'd1,  5'd5, 1'b0, O_LU};
        tbl[2] = '{"lu_rs",          1'b1, 5'd5,  5'd5,  5'd2, 1'b0, O_LU};
        tbl[3] = '{"lu_r0",          1'b1, 5'd0,  5'd0,  5'd0, 1'b0, O_NORM};
        tbl[4] = '{"lu_not_load",    1'b0, 5'd5,  5'd5,  5'd5, 1'b0, O_NORM};
        tbl[5] = '{"lu_no_match",    1'b1, 5'd5,  5'd6,  5'd7, 1'b0, O_NORM};
        tbl[6] = '{"br_over_lu",     1'b1, 5'd5,  5'd1,  5'd5, 1'b1, O_BR};
        tbl[7] = '{"br_alone",       1'b0, 5'd0,  5'd0,  5'd0, 1'b1, O_BR};
        tbl[8] = '{"lu_r31",         1'b1, 5'd31, 5'd31, 5'd0, 1'b0, O_LU};

        idle_inputs();
        last = '0;
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Single-cycle decode in IDLE from the vector table.
        for (int i = 0; i < 9; i++) begin
            md_start = 0; md_is_div = 0; dx_is_load = tbl[i].ld; dx_rd = tbl[i].rd;
            fd_rs = tbl[i].rs; fd_rt = tbl[i].rt; branch_taken = tbl[i].br;
            @(negedge clock);
            check(tbl[i].name, {22'd0, outs}, {22'd0, tbl[i].exp});
            @(posedge clock);
            #1;
        end

        run_md("mult", 1'b0, MULT_N);
        run_md("div", 1'b1, DIV_N);

        // Reset during BUSY cycle 10 of a divide.
        cycle(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("busy_before_rst", {31'd0, md_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("busy_async_clr", {31'd0, md_busy}, 32'd0);
        check("outs_async_rst", {22'd0, outs}, {22'd0, O_NORM});
        occ = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        run_md("div_after_rst", 1'b1, DIV_N);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0));
        end

`ifdef PIPELINE_CTRL_PERF_EN
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < MULT_N - 1; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
        check("stall_count", stall_count, 32'd31);
        check("flush_count", flush_count, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the five-stage pipeline latches (F/D, D/X, X/M, M/W) and the PC register.
- Generates per-latch write enables and flush (bubble-insert) controls.
- Handles three hazard sources: multi-cycle mult/div stalls, load-use stalls and taken-branch flushes.
- Owns the mult/div cycle counter, so the latches stay plain always-enabled registers unless this block freezes them.

Parameters:
- MULT_CYCLES, 32, total cycles a multiply occupies X (must be at least 2)
- DIV_CYCLES, 32, total cycles a divide occupies X (must be at least 2)
- CNT_W, 6, width of the busy counter (must hold max(MULT_CYCLES, DIV_CYCLES)-1)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous reset, active-low
- md_start  input  1  mult/div instruction present in X this cycle
- md_is_div  input  1  qualifies md_start: 1=divide, 0=multiply
- dx_is_load  input  1  instruction in X is a load
- dx_rd  input  5  destination register of instruction in X
- fd_rs  input  5  source register A of instruction in D
- fd_rt  input  5  source register B of instruction in D
- branch_taken  input  1  branch/jump resolved taken in X
- pc_we  output  1  PC write enable
- fd_we  output  1  F/D latch write enable
- dx_we  output  1  D/X latch write enable
- xm_we  output  1  X/M latch write enable
- mw_we  output  1  M/W latch write enable
- fd_flush  output  1  load NOP into F/D
- dx_flush  output  1  load NOP into D/X
- xm_flush  output  1  load NOP into X/M
- md_busy  output  1  mult/div in progress
- md_done  output  1  one-cycle pulse when mult/div result is captured

Behaviour:
- State machine states: IDLE, BUSY, DONE. Counter cnt is CNT_W bits wide.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0.
  - Outputs: pc_we=fd_we=dx_we=xm_we=mw_we=1; all flushes=0; md_busy=0; md_done=0.
- IDLE:
  - On md_start=1 go to BUSY, with cnt = (md_is_div ? DIV_CYCLES : MULT_CYCLES) - 2.
  - The start cycle itself already stalls: pc_we=fd_we=dx_we=0 and xm_flush=1.
- BUSY:
  - pc_we=fd_we=dx_we=0, xm_flush=1, md_busy=1.
  - cnt decrements each cycle.
  - When cnt==0, go to DONE on the next edge.
- DONE (one cycle):
  - md_done=1, md_busy=0, all write enables=1, xm_flush=0; X/M captures the result.
  - Next state is IDLE.
  - md_start is not re-sampled in DONE, because the X instruction advances this cycle.
- Mult/div occupancy: the instruction stays in X for exactly N cycles (the start cycle, N-2 BUSY cycles and the DONE cycle).
- md_start is ignored in BUSY and DONE.
- mw_we=1 in all states. M/W keeps draining and receives bubbles during a stall.
- Load-use hazard: dx_is_load && dx_rd!=0 && (dx_rd==fd_rs || dx_rd==fd_rt).
  - Evaluated only in IDLE with md_start=0.
  - Response: pc_we=0, fd_we=0, dx_flush=1; other latches are enabled.
  - Exactly one bubble per hazard.
- Taken branch: branch_taken=1 in IDLE with md_start=0 gives fd_flush=1 and dx_flush=1, with all write enables=1.
- Priority: mult/div stall > branch flush > load-use stall.
  - A branch coincident with a load-use hazard flushes; no stall is applied.
  - branch_taken in BUSY or DONE is ignored, because X holds the mult/div.
- All outputs are combinational from state and inputs; only state and cnt are registered.
- Reset asserted mid-BUSY returns to IDLE immediately and aborts the counter.
- Register 0 never causes a load-use stall.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- When defined, two extra outputs are present:
  - stall_count, 32-bit: increments on every cycle with pc_we=0.
  - flush_count, 32-bit: increments on every cycle with fd_flush=1.
- Both counters reset to 0 on reset and wrap modulo 2^32.
- When not defined, the ports and counters are absent and functional behaviour is identical.

Test Plan:
- Reset: release reset with all inputs 0 -> all we=1, flushes=0, md_busy=0.
- Multiply: pulse md_start=1, md_is_div=0, MULT_CYCLES=32 -> pc_we=0 for exactly 31 cycles; md_done high on cycle 32 only; then IDLE with all we=1.
- Load-use: dx_is_load=1, dx_rd=5, fd_rt=5 -> one cycle with pc_we=0, fd_we=0, dx_flush=1. Same stimulus with dx_rd=0 -> no stall.
- Branch: branch_taken=1 together with a load-use hazard -> fd_flush=dx_flush=1, pc_we=1, no stall.
- Reset mid-mult/div: start a divide, assert reset at BUSY cycle 10 -> md_busy=0 asynchronously; after release, a new md_start gives a full DIV_CYCLES stall.
- Perf counters (with PIPELINE_CTRL_PERF_EN): one multiply (32 cycles) plus one branch -> stall_count=31, flush_count=1.
